// File: rtl/palette_arbiter_if.sv
// palette_arbiter_if: requester lanes, palette decoder link and tagged response bus of palette_arbiter.
// slave modport: the arbiter; master modport: the sources, decoder and compositor around it.
interface palette_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0] req;
  logic [6*NUM_REQ-1:0] req_index;
  logic [NUM_REQ-1:0] req_last;
  logic [NUM_REQ-1:0] gnt;
  logic [5:0] pal_index;
  logic [23:0] pal_color;
  logic rsp_valid;
  logic [$clog2(NUM_REQ)-1:0] rsp_id;
  logic [23:0] rsp_color;
  logic busy;
  modport slave (
    input req, req_index, req_last, pal_color,
    output gnt, pal_index, rsp_valid, rsp_id, rsp_color, busy
  );
  modport master (
    output req, req_index, req_last, pal_color,
    input gnt, pal_index, rsp_valid, rsp_id, rsp_color, busy
  );
endinterface

// File: rtl/palette_arbiter.sv
// palette_arbiter: round-robin burst arbiter sharing one palette decoder, with 1-cycle tagged RGB responses.
// Ports: Clk, Reset_n (async, active-low), bus (palette_arbiter_if.slave: req/req_index/req_last in,
// gnt/pal_index out, pal_color in, rsp_valid/rsp_id/rsp_color/busy out).
// Optional PALETTE_ARB_OOR_ERR_EN adds oor_err (sticky out-of-range flag) and oor_id (first offender).
module palette_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int MAX_BURST = 16
) (
  input logic Clk,
  input logic Reset_n,
  palette_arbiter_if.slave bus
`ifdef PALETTE_ARB_OOR_ERR_EN
  ,
  output logic oor_err,
  output logic [$clog2(NUM_REQ)-1:0] oor_id
`endif
);
  localparam int IDW = $clog2(NUM_REQ);
  localparam logic [7:0] MAXB = 8'(MAX_BURST);
  localparam logic [IDW-1:0] LAST_ID = IDW'(NUM_REQ - 1);
  typedef enum logic {IDLE, BURST} state_t;
  state_t state, state_nx;
  logic [IDW-1:0] owner, owner_nx, rr_ptr, rr_nx, pick;
  logic [7:0] burst_cnt, cnt_nx;
  logic [5:0] lane [NUM_REQ];
  logic [5:0] lane_idx;
  logic found, accept, done, oor;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    assign lane[i] = bus.req_index[6*i +: 6];
  end

  // first requesting lane at or after rr_ptr, wrapping
  always_comb begin
    pick = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && bus.req[IDW'((int'(rr_ptr) + k) % NUM_REQ)]) begin
        found = 1'b1;
        pick = IDW'((int'(rr_ptr) + k) % NUM_REQ);
      end
    end
  end

  always_comb begin
    lane_idx = lane[owner];
    accept = (state == BURST) && bus.req[owner];
    // a dropped request ends the burst with nothing accepted
    done = !accept || bus.req_last[owner] || (burst_cnt + 8'd1 == MAXB);
    oor = lane_idx > 6'd35;
    bus.busy = state == BURST;
  end

  always_comb begin
    state_nx = state;
    owner_nx = owner;
    rr_nx = rr_ptr;
    cnt_nx = burst_cnt;
    bus.gnt = '0;
    bus.pal_index = 6'd0;
    if (state == IDLE) begin
      if (found) begin
        state_nx = BURST;
        owner_nx = pick;
        cnt_nx = 8'd0;
      end
    end else begin
      bus.gnt[owner] = bus.req[owner];
      if (accept) begin
        bus.pal_index = lane_idx;
        cnt_nx = burst_cnt + 8'd1;
      end
      if (done) begin
        state_nx = IDLE;
        rr_nx = (owner == LAST_ID) ? '0 : owner + 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
      owner <= '0;
      rr_ptr <= '0;
      burst_cnt <= 8'd0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id <= '0;
      bus.rsp_color <= 24'd0;
    end else begin
      state <= state_nx;
      owner <= owner_nx;
      rr_ptr <= rr_nx;
      burst_cnt <= cnt_nx;
      bus.rsp_valid <= accept;
      if (accept) begin
        bus.rsp_id <= owner;
        bus.rsp_color <= oor ? 24'd0 : bus.pal_color;
      end
    end
  end

`ifdef PALETTE_ARB_OOR_ERR_EN
  // sticky; oor_id keeps the first offender
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      oor_err <= 1'b0;
      oor_id <= '0;
    end else if (accept && oor && !oor_err) begin
      oor_err <= 1'b1;
      oor_id <= owner;
    end
  end
`endif

endmodule
